// File: rtl/subparser_dispatcher.sv
// subparser_dispatcher: hands one decoded G-code command to its owning
// subparser (slot 0 modal G90/G91, slot 1 linear G00/G01, slot 2 arc G02/G03),
// drives that slot's trigger, captures its op and offers it downstream.
// Only one subparser is ever active, so the slots can share the token reader
// and the PositionKeeper update port.
//
// Handshakes: cmd transfers on an enabled edge with cmd_valid=1 in IDLE
// (cmd_rdy=1). The trigger is held until the selected slot's rdy is seen low
// (started); the slot's done pulse then delivers its op. op/op_valid
// transfer on an enabled edge with op_ack=1. The dispatcher leaves HOLD only
// after both the ack and the slot's rdy returning high have been seen, in
// either order.
//
// Optional feature: define SUBPARSER_TIMEOUT_EN to add a watchdog in TRIG and
// RUN that aborts after TIMEOUT_CYCLES enabled clocks and pulses err_timeout.
`ifndef OP_CMD_BITS
`define OP_CMD_BITS 8
`endif

module subparser_dispatcher #(
    parameter int NUM_SUB        = 3,
    parameter int OP_BITS        = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clk_en,
    input  logic                       cmd_valid,
    input  logic [`OP_CMD_BITS-1:0]    cmd,
    output logic                       cmd_rdy,
    output logic [NUM_SUB-1:0]         sub_trigger,
    input  logic [NUM_SUB-1:0]         sub_rdy,
    input  logic [NUM_SUB-1:0]         sub_done,
    input  logic [NUM_SUB*OP_BITS-1:0] sub_op,
    output logic [OP_BITS-1:0]         op,
    output logic                       op_valid,
    input  logic                       op_ack,
    output logic                       busy,
    output logic                       err_unsupported,
`ifdef SUBPARSER_TIMEOUT_EN
    output logic                       err_timeout,
`endif
    output logic [1:0]                 dbg_state
);

    localparam int SEL_W = (NUM_SUB > 1) ? $clog2(NUM_SUB) : 1;

    localparam logic [`OP_CMD_BITS-1:0] OP_CMD_G00 = `OP_CMD_BITS'(0);
    localparam logic [`OP_CMD_BITS-1:0] OP_CMD_G01 = `OP_CMD_BITS'(1);
    localparam logic [`OP_CMD_BITS-1:0] OP_CMD_G02 = `OP_CMD_BITS'(2);
    localparam logic [`OP_CMD_BITS-1:0] OP_CMD_G03 = `OP_CMD_BITS'(3);
    localparam logic [`OP_CMD_BITS-1:0] OP_CMD_G90 = `OP_CMD_BITS'(90);
    localparam logic [`OP_CMD_BITS-1:0] OP_CMD_G91 = `OP_CMD_BITS'(91);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRIG = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [OP_BITS-1:0]   op_q, op_d;
    logic                 op_valid_q, op_valid_d;
    logic                 rdy_seen_q, rdy_seen_d;
    logic                 err_unsup_q, err_unsup_d;

    logic                 map_valid;
    logic [SEL_W-1:0]     map_slot;
    logic [NUM_SUB-1:0]   sel_oh;
    logic                 sel_rdy;
    logic                 sel_done;
    logic [OP_BITS-1:0]   sel_op;

`ifdef SUBPARSER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]      wd_q, wd_d;
    logic                 err_to_q, err_to_d;
`endif

    // Command code to owning slot; anything not listed has no owner.
    always_comb begin
        map_valid = 1'b1;
        map_slot  = '0;
        case (cmd)
            OP_CMD_G90, OP_CMD_G91: map_slot = SEL_W'(0);
            OP_CMD_G00, OP_CMD_G01: map_slot = SEL_W'(1);
            OP_CMD_G02, OP_CMD_G03: map_slot = SEL_W'(2);
            default:                map_valid = 1'b0;
        endcase
    end

    // Pick out the selected slot's signals; other slots are never looked at.
    always_comb begin
        sel_oh   = '0;
        sel_rdy  = 1'b0;
        sel_done = 1'b0;
        sel_op   = '0;
        for (int k = 0; k < NUM_SUB; k++) begin
            if (sel_q == SEL_W'(k)) begin
                sel_oh[k] = 1'b1;
                sel_rdy   = sub_rdy[k];
                sel_done  = sub_done[k];
                sel_op    = sub_op[k*OP_BITS +: OP_BITS];
            end
        end
    end

    // Next-state logic for the dispatch FSM and its datapath registers.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        op_d        = op_q;
        op_valid_d  = op_valid_q;
        rdy_seen_d  = rdy_seen_q;
        err_unsup_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (map_valid) begin
                        sel_d   = map_slot;
                        state_d = TRIG;
                    end else begin
                        err_unsup_d = 1'b1;
                    end
                end
            end
            TRIG: begin
                if (!sel_rdy) state_d = RUN;
            end
            RUN: begin
                if (sel_done) begin
                    op_d       = sel_op;
                    op_valid_d = 1'b1;
                    rdy_seen_d = 1'b0;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (op_ack) op_valid_d = 1'b0;
                if (sel_rdy) rdy_seen_d = 1'b1;
                if ((!op_valid_q || op_ack) && (rdy_seen_q || sel_rdy))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef SUBPARSER_TIMEOUT_EN
        err_to_d = 1'b0;
        wd_d     = '0;
        if ((state_q == TRIG || state_q == RUN) && state_d == state_q) begin
            if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                state_d  = IDLE;
                err_to_d = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif
    end

    // State and datapath registers; clk_en freezes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            op_q        <= '0;
            op_valid_q  <= 1'b0;
            rdy_seen_q  <= 1'b0;
            err_unsup_q <= 1'b0;
`ifdef SUBPARSER_TIMEOUT_EN
            wd_q        <= '0;
            err_to_q    <= 1'b0;
`endif
        end else if (clk_en) begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            op_q        <= op_d;
            op_valid_q  <= op_valid_d;
            rdy_seen_q  <= rdy_seen_d;
            err_unsup_q <= err_unsup_d;
`ifdef SUBPARSER_TIMEOUT_EN
            wd_q        <= wd_d;
            err_to_q    <= err_to_d;
`endif
        end
    end

    assign cmd_rdy         = (state_q == IDLE);
    assign busy            = (state_q != IDLE);
    assign sub_trigger     = (state_q == TRIG) ? sel_oh : '0;
    assign op              = op_q;
    assign op_valid        = op_valid_q;
    assign err_unsupported = err_unsup_q;
    assign dbg_state       = state_q;
`ifdef SUBPARSER_TIMEOUT_EN
    assign err_timeout     = err_to_q;
`endif

endmodule

// File: tb/tb_subparser_dispatcher.sv
// Directed bench for subparser_dispatcher: the subparser bank is played by
// the stimulus sequence, and ops a slot delivers are queued and compared
// when the dispatcher presents them.
module tb_subparser_dispatcher;

    localparam int NUM_SUB = 3;
    localparam int OP_BITS = 32;
    localparam int CB      = 8;

    localparam logic [CB-1:0] C_G00 = 8'd0;
    localparam logic [CB-1:0] C_G01 = 8'd1;
    localparam logic [CB-1:0] C_G02 = 8'd2;
    localparam logic [CB-1:0] C_G03 = 8'd3;
    localparam logic [CB-1:0] C_G90 = 8'd90;
    localparam logic [CB-1:0] C_G91 = 8'd91;
    localparam logic [CB-1:0] C_M03 = 8'd203;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic                       clk_en = 1'b1;
    logic                       cmd_valid = 1'b0;
    logic [CB-1:0]              cmd = '0;
    logic                       cmd_rdy;
    logic [NUM_SUB-1:0]         sub_trigger;
    logic [NUM_SUB-1:0]         sub_rdy = '1;
    logic [NUM_SUB-1:0]         sub_done = '0;
    logic [NUM_SUB*OP_BITS-1:0] sub_op = '0;
    logic [OP_BITS-1:0]         op;
    logic                       op_valid;
    logic                       op_ack = 1'b0;
    logic                       busy;
    logic                       err_unsupported;
    logic [1:0]                 dbg_state;
`ifdef SUBPARSER_TIMEOUT_EN
    logic                       err_timeout;
`endif

    subparser_dispatcher #(
        .NUM_SUB(NUM_SUB), .OP_BITS(OP_BITS), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .sub_trigger(sub_trigger), .sub_rdy(sub_rdy), .sub_done(sub_done),
        .sub_op(sub_op), .op(op), .op_valid(op_valid), .op_ack(op_ack),
        .busy(busy), .err_unsupported(err_unsupported),
`ifdef SUBPARSER_TIMEOUT_EN
        .err_timeout(err_timeout),
`endif
        .dbg_state(dbg_state)
    );

    // scoreboard
    logic [OP_BITS-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock; outputs are sampled 1ns after the edge, inputs change there too
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // slot delivers a fresh random op with a done pulse
    task automatic deliver(input int slot);
        logic [OP_BITS-1:0] v;
        v = OP_BITS'($urandom);
        sub_op[slot*OP_BITS +: OP_BITS] = v;
        exp_q.push_back(v);
        sub_done[slot] = 1'b1;
        tick();
        sub_done[slot] = 1'b0;
    endtask

    // compare presented op against the oldest queued expectation
    task automatic expect_op(input string tag);
        logic [OP_BITS-1:0] e;
        check({tag, "_valid"}, 64'(op_valid), 64'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_op"}, 64'(op), 64'(e));
        end
    endtask

    // full dispatch with a quick subparser and immediate ack
    task automatic dispatch(input logic [CB-1:0] c, input int slot, input string tag);
        cmd = c;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check({tag, "_trig"}, 64'(sub_trigger), 64'(3'b001 << slot));
        check({tag, "_cmd_rdy_low"}, 64'(cmd_rdy), 64'd0);
        sub_rdy[slot] = 1'b0;
        tick();
        check({tag, "_trig_drop"}, 64'(sub_trigger), 64'd0);
        deliver(slot);
        expect_op(tag);
        op_ack = 1'b1;
        sub_rdy[slot] = 1'b1;
        tick();
        op_ack = 1'b0;
        check({tag, "_valid_clr"}, 64'(op_valid), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        // reset for 2 cycles
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_trig", 64'(sub_trigger), 64'd0);
        check("rst_op", 64'(op), 64'd0);
        check("rst_valid", 64'(op_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err_unsupported), 64'd0);
        check("rst_cmd_rdy", 64'(cmd_rdy), 64'd1);
        check("rst_state", 64'(dbg_state), 64'd0);

        // G91 with an ideal subparser: op_valid three edges after accept
        cmd = C_G91;
        cmd_valid = 1'b1;
        tick();                                   // accept edge N
        cmd_valid = 1'b0;
        check("g91_trig", 64'(sub_trigger), 64'b001);
        check("g91_busy", 64'(busy), 64'd1);
        check("g91_cmd_rdy", 64'(cmd_rdy), 64'd0);
        tick();                                   // N+1: rdy still high
        check("g91_trig_held", 64'(sub_trigger), 64'b001);
        sub_rdy[0] = 1'b0;
        tick();                                   // N+2: started
        check("g91_trig_drop", 64'(sub_trigger), 64'd0);
        check("g91_no_valid_yet", 64'(op_valid), 64'd0);
        deliver(0);                               // N+3
        expect_op("g91_latency");
        tick();
        check("g91_hold_valid", 64'(op_valid), 64'd1);
        op_ack = 1'b1;
        tick();
        op_ack = 1'b0;
        check("g91_ack_clr", 64'(op_valid), 64'd0);
        check("g91_wait_rdy", 64'(busy), 64'd1);
        sub_rdy[0] = 1'b1;
        tick();
        check("g91_done_busy", 64'(busy), 64'd0);
        check("g91_done_cmd_rdy", 64'(cmd_rdy), 64'd1);

        // back-to-back G91 then G90 with op_ack tied high
        op_ack = 1'b1;
        cmd = C_G91;
        cmd_valid = 1'b1;
        tick();
        cmd = C_G90;                              // second command waits
        sub_rdy[0] = 1'b0;
        tick();
        deliver(0);
        expect_op("b2b_first");
        tick();                                   // acked, slot 0 not back yet
        check("b2b_valid_clr", 64'(op_valid), 64'd0);
        check("b2b_cmd_rdy_low", 64'(cmd_rdy), 64'd0);
        check("b2b_no_retrig", 64'(sub_trigger), 64'd0);
        sub_rdy[0] = 1'b1;
        tick();                                   // back to IDLE
        check("b2b_idle_no_trig", 64'(sub_trigger), 64'd0);
        check("b2b_idle_cmd_rdy", 64'(cmd_rdy), 64'd1);
        tick();                                   // G90 accepted
        cmd_valid = 1'b0;
        check("b2b_second_trig", 64'(sub_trigger), 64'b001);
        sub_rdy[0] = 1'b0;
        tick();
        deliver(0);
        expect_op("b2b_second");
        sub_rdy[0] = 1'b1;
        tick();
        op_ack = 1'b0;
        check("b2b_end_idle", 64'(busy), 64'd0);

        // G01 while slot 2 raises done/rdy spuriously
        cmd = C_G01;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        sub_done[2] = 1'b1;
        sub_rdy[2] = 1'b0;
        tick();
        check("iso_trig_held", 64'(sub_trigger), 64'b010);
        sub_rdy[2] = 1'b1;
        sub_rdy[1] = 1'b0;
        sub_op[2*OP_BITS +: OP_BITS] = 32'hDEAD_BEEF;
        tick();                                   // RUN, slot 2 done still high
        tick();
        sub_done[2] = 1'b0;
        check("iso_no_capture", 64'(op_valid), 64'd0);
        check("iso_still_busy", 64'(busy), 64'd1);
        deliver(1);
        expect_op("iso_slot1");
        op_ack = 1'b1;
        sub_rdy[1] = 1'b1;
        tick();
        op_ack = 1'b0;
        check("iso_idle", 64'(busy), 64'd0);

        // unmapped command, including a frozen error pulse
        cmd = C_M03;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("unsup_err", 64'(err_unsupported), 64'd1);
        check("unsup_no_trig", 64'(sub_trigger), 64'd0);
        check("unsup_idle", 64'(busy), 64'd0);
        tick();
        check("unsup_pulse_end", 64'(err_unsupported), 64'd0);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        clk_en = 1'b0;
        tick();
        tick();
        check("freeze_err_held", 64'(err_unsupported), 64'd1);
        clk_en = 1'b1;
        tick();
        check("freeze_err_clr", 64'(err_unsupported), 64'd0);
        dispatch(C_G90, 0, "after_unsup_g90");

        // reset while G02 is running
        cmd = C_G02;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        sub_rdy[2] = 1'b0;
        tick();
        check("rstrun_in_run", 64'(dbg_state), 64'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sub_rdy[2] = 1'b1;
        check("rstrun_trig", 64'(sub_trigger), 64'd0);
        check("rstrun_valid", 64'(op_valid), 64'd0);
        check("rstrun_busy", 64'(busy), 64'd0);
        dispatch(C_G00, 1, "after_rst_g00");
        dispatch(C_G03, 2, "g03");

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
